// File: rtl/control_path_mc.sv
// Multi-cycle control path: PC, instruction register and a FETCH/EXEC/MEM/HALT FSM
// that drives the register-file, function-unit and data-memory strobes.
module control_path_mc #(
    parameter int unsigned RAW = 4,
    parameter int unsigned PCW = 6,
    parameter int unsigned DW  = 4
) (
    input  logic               clk_main_i,
    input  logic               reset_i,
    input  logic [3*RAW+3:0]   instr_in_i,
    input  logic               instr_valid_i,
    input  logic               mem_ready_i,
    input  logic               z_i,
    input  logic               n_i,
    input  logic [DW-1:0]      bus_a_i,
    input  logic               resume_i,
    output logic [PCW-1:0]     pc_o,
    output logic [RAW-1:0]     dr_o,
    output logic [RAW-1:0]     sa_o,
    output logic [RAW-1:0]     sb_o,
    output logic [3:0]         fs_o,
    output logic               mb_o,
    output logic               md_o,
    output logic               rw_o,
    output logic               mw_o,
    output logic               mr_o,
    output logic               halted_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StMem   = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [3*RAW+3:0]   ir_q, ir_d;

    logic [3:0]         opcode;
    logic [PCW-1:0]     br_off;
    logic [PCW-1:0]     br_target;

    assign opcode = ir_q[3*RAW+3:3*RAW];
    assign dr_o   = ir_q[3*RAW-1:2*RAW];
    assign sa_o   = ir_q[2*RAW-1:RAW];
    assign sb_o   = ir_q[RAW-1:0];

    // Sign-extend (or truncate) the DR field into a PC-wide branch offset.
    assign br_off    = PCW'($signed(dr_o));
    assign br_target = pc_q + br_off;

    always_ff @(posedge clk_main_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        fs_o     = 4'h0;
        mb_o     = 1'b0;
        md_o     = 1'b0;
        rw_o     = 1'b0;
        mw_o     = 1'b0;
        mr_o     = 1'b0;
        halted_o = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (instr_valid_i) begin
                    ir_d    = instr_in_i;
                    pc_d    = pc_q + PCW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (!opcode[3]) begin
                    fs_o = opcode;
                    rw_o = 1'b1;
                end else begin
                    case (opcode)
                        4'h8: begin
                            fs_o = 4'h2;
                            mb_o = 1'b1;
                            rw_o = 1'b1;
                        end
                        4'h9: begin
                            mr_o    = 1'b1;
                            state_d = StMem;
                        end
                        4'hA: begin
                            mw_o    = 1'b1;
                            state_d = StMem;
                        end
                        4'hB: if (z_i) pc_d = br_target;
                        4'hC: if (n_i) pc_d = br_target;
                        4'hD: pc_d = PCW'(bus_a_i);
                        4'hF: state_d = StHalt;
                        default: ;
                    endcase
                end
            end
            StMem: begin
                // Only LD and ST ever enter MEM, so opcode bit 0 picks between them.
                if (opcode == 4'h9) begin
                    mr_o = 1'b1;
                    if (mem_ready_i) begin
                        md_o    = 1'b1;
                        rw_o    = 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    mw_o = 1'b1;
                    if (mem_ready_i) state_d = StFetch;
                end
            end
            StHalt: begin
                halted_o = 1'b1;
                if (resume_i) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    assign pc_o    = pc_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_control_path_mc.sv
// Scoreboard bench for control_path_mc: a cycle-level reference model predicts every
// output sample; a negedge monitor pops and compares against the DUT.
module tb_control_path_mc;

    localparam int RAW = 4;
    localparam int PCW = 6;
    localparam int DW  = 4;
    localparam int PCM = 1 << PCW;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] pc;
        logic [3:0] dr;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] fs;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       halted;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        valid, ready, z, n, resume;
    logic [3:0]  bus_a;
    logic [5:0]  pc;
    logic [3:0]  dr, sa, sb, fs;
    logic        mb, md, rw, mw, mr, halted;
    logic [1:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;
    obs_t exp_q[$];

    // Reference model: architectural state only.
    int          m_pc;
    logic [15:0] m_ir;
    int          m_st;

    always #5 clk = ~clk;

    control_path_mc #(.RAW(RAW), .PCW(PCW), .DW(DW)) dut (
        .clk_main_i   (clk),
        .reset_i      (rst),
        .instr_in_i   (instr),
        .instr_valid_i(valid),
        .mem_ready_i  (ready),
        .z_i          (z),
        .n_i          (n),
        .bus_a_i      (bus_a),
        .resume_i     (resume),
        .pc_o         (pc),
        .dr_o         (dr),
        .sa_o         (sa),
        .sb_o         (sb),
        .fs_o         (fs),
        .mb_o         (mb),
        .md_o         (md),
        .rw_o         (rw),
        .mw_o         (mw),
        .mr_o         (mr),
        .halted_o     (halted),
        .state_o      (state)
    );

    function automatic logic [15:0] mk(input int op, input int d, input int a, input int b);
        mk = {op[3:0], d[3:0], a[3:0], b[3:0]};
    endfunction

    function automatic obs_t sample();
        sample = '{st: state, pc: pc, dr: dr, sa: sa, sb: sb, fs: fs, mb: mb, md: md,
                   rw: rw, mw: mw, mr: mr, halted: halted};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_ir = '0;
        m_st = 0;
    endtask

    // Monitor: every out-of-reset cycle with a prediction pending is compared.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle@%0t: got st=%0d pc=%0d fs=%h mb%b md%b rw%b mw%b mr%b h%b ir=%h%h%h, expected st=%0d pc=%0d fs=%h mb%b md%b rw%b mw%b mr%b h%b ir=%h%h%h",
                         $time, a.st, a.pc, a.fs, a.mb, a.md, a.rw, a.mw, a.mr, a.halted,
                         a.dr, a.sa, a.sb, e.st, e.pc, e.fs, e.mb, e.md, e.rw, e.mw, e.mr,
                         e.halted, e.dr, e.sa, e.sb);
            end
        end
    end

    // One clock cycle: drive inputs, predict outputs, advance the model, move past the edge.
    task automatic step(input logic v, input logic [15:0] ins, input logic rdy, input logic zz,
                        input logic nn, input logic [3:0] ba, input logic res);
        obs_t e;
        int   op, off, n_pc, n_st;
        logic [15:0] n_ir;
        valid = v; instr = ins; ready = rdy; z = zz; n = nn; bus_a = ba; resume = res;
        e = '0;
        e.st = m_st[1:0];
        e.pc = m_pc[5:0];
        e.dr = m_ir[11:8];
        e.sa = m_ir[7:4];
        e.sb = m_ir[3:0];
        op   = int'(m_ir[15:12]);
        off  = (m_ir[11:8] >= 4'd8) ? int'(m_ir[11:8]) - 16 : int'(m_ir[11:8]);
        n_pc = m_pc; n_st = m_st; n_ir = m_ir;
        case (m_st)
            0: if (v) begin
                n_ir = ins;
                n_pc = (m_pc + 1) % PCM;
                n_st = 1;
            end
            1: begin
                n_st = 0;
                if (op < 8) begin
                    e.fs = op[3:0]; e.rw = 1'b1;
                end else if (op == 8) begin
                    e.fs = 4'h2; e.mb = 1'b1; e.rw = 1'b1;
                end else if (op == 9) begin
                    e.mr = 1'b1; n_st = 2;
                end else if (op == 10) begin
                    e.mw = 1'b1; n_st = 2;
                end else if ((op == 11 && zz) || (op == 12 && nn)) begin
                    n_pc = (m_pc + off + PCM) % PCM;
                end else if (op == 13) begin
                    n_pc = int'(ba) % PCM;
                end else if (op == 15) begin
                    n_st = 3;
                end
            end
            2: begin
                if (op == 9) begin
                    e.mr = 1'b1;
                    if (rdy) begin e.md = 1'b1; e.rw = 1'b1; end
                end else begin
                    e.mw = 1'b1;
                end
                if (rdy) n_st = 0;
            end
            default: begin
                e.halted = 1'b1;
                if (res) n_st = 0;
            end
        endcase
        exp_q.push_back(e);
        m_pc = n_pc; m_st = n_st; m_ir = n_ir;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid = 0; instr = '0; ready = 0; z = 0; n = 0; bus_a = '0; resume = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_pc", int'(pc), 0);
        check("reset_strobes", int'({fs, mb, md, rw, mw, mr, halted}), 0);
        rst = 1'b0;

        // ALU 0x3 at pc=0, then back to FETCH.
        step(1, mk(3, 1, 2, 3), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // LD with mem_ready low for three MEM cycles.
        step(1, mk(9, 2, 1, 0), 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Branches at pc=5 with offset -2, taken and not taken.
        for (int br = 11; br <= 12; br++) begin
            for (int t = 1; t >= 0; t--) begin
                step(1, mk(13, 0, 0, 0), 0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0, 4'd5, 0);
                step(1, mk(br, 14, 0, 0), 0, 0, 0, 0, 0);
                step(0, 0, 0, t[0], t[0], 0, 0);
                idle(1);
            end
        end

        // Wrap-around: reach pc=63, fetch wraps to 0, branch -1 returns to 63.
        do_reset();
        step(1, mk(11, 14, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, mk(11, 15, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // JMP to 11, HLT with resume in EXEC ignored, ten frozen cycles, then resume.
        step(1, mk(13, 0, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'hB, 0);
        step(1, mk(15, 5, 6, 7), 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, mk(3, 0, 0, 0), 1, 1, 1, 4'h7, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Async reset mid-cycle while ST sits in MEM.
        step(1, mk(10, 3, 4, 5), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        ready = 1'b0; valid = 1'b0;
        #1;
        check("st_mem_mw_before_reset", int'(mw), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_mw", int'(mw), 0);
        check("async_reset_state", int'(state), 0);
        check("async_reset_pc", int'(pc), 0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, mk(14, 0, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 15);
            if (op == 15 && $urandom_range(0, 3) != 0) op = 14;
            step(($urandom_range(0, 3) != 0),
                 mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                 ($urandom_range(0, 4) > 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
